// File: rtl/tc_pkg.sv
// Shared encodings for the tensor-core result path: out_state beats, error codes
// and the collector FSM state type.
package tc_pkg;

    localparam logic [1:0] TC_OS_IDLE = 2'b00;
    localparam logic [1:0] TC_OS_BEAT = 2'b01;
    localparam logic [1:0] TC_OS_LAST = 2'b11;

    localparam logic [1:0] TC_ERR_NONE    = 2'b00;
    localparam logic [1:0] TC_ERR_SHORT   = 2'b01;
    localparam logic [1:0] TC_ERR_OVF     = 2'b10;
    localparam logic [1:0] TC_ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        TC_ST_IDLE,
        TC_ST_COLLECT,
        TC_ST_DONE,
        TC_ST_ERR
    } tc_state_e;

endpackage

// File: rtl/tc_result_ram.sv
// Simple dual-port result buffer: one write port, one registered read-first read port.
// The array itself is never reset; only the read data register is.
module tc_result_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem gives read-first behaviour on an address collision.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tc_result_collector.sv
// Captures one M x N result matrix from tc_ctrl in row-major order into a local
// buffer and exposes frame status plus a registered read port.
module tc_result_collector
    import tc_pkg::*;
#(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int DW_ADD  = 32,
    parameter int TIMEOUT = 1024,
    localparam int DEPTH  = M * N,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic signed [DW_ADD-1:0] out_i,
    input  logic [1:0]               out_state,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [DW_ADD-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [CW-1:0]            beat_cnt
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    tc_state_e     state_d, state_q;
    logic [CW-1:0] beat_cnt_d, beat_cnt_q;
    logic [TW-1:0] timer_d, timer_q;
    logic [1:0]    err_code_d, err_code_q;
    logic          rd_valid_q;
    logic          beat;
    logic          last;
    logic          we;

    // Reserved encoding 2'b10 falls out as idle here.
    assign beat = (out_state == TC_OS_BEAT) || (out_state == TC_OS_LAST);
    assign last = (out_state == TC_OS_LAST);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        timer_d    = timer_q;
        err_code_d = err_code_q;
        we         = 1'b0;
        if (arm) begin
            state_d    = TC_ST_COLLECT;
            beat_cnt_d = '0;
            timer_d    = '0;
            err_code_d = TC_ERR_NONE;
        end else begin
            case (state_q)
                TC_ST_COLLECT: begin
                    if (beat) begin
                        we         = 1'b1;
                        beat_cnt_d = beat_cnt_q + CW'(1);
                        timer_d    = '0;
                        if (beat_cnt_q == CW'(DEPTH - 1)) begin
                            state_d = TC_ST_DONE;
                        end else if (last) begin
                            state_d    = TC_ST_ERR;
                            err_code_d = TC_ERR_SHORT;
                        end
                    end else if (TIMEOUT != 0) begin
                        timer_d = timer_q + TW'(1);
                        if (timer_q == TW'(TIMEOUT - 1)) begin
                            state_d    = TC_ST_ERR;
                            err_code_d = TC_ERR_TIMEOUT;
                        end
                    end
                end
                TC_ST_DONE: begin
                    if (beat) begin
                        state_d    = TC_ST_ERR;
                        err_code_d = TC_ERR_OVF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TC_ST_IDLE;
            beat_cnt_q <= '0;
            timer_q    <= '0;
            err_code_q <= TC_ERR_NONE;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            timer_q    <= timer_d;
            err_code_q <= err_code_d;
            rd_valid_q <= rd_en;
        end
    end

    // beat_cnt never exceeds DEPTH-1 while writing, so its low bits are the write address.
    tc_result_ram #(
        .DEPTH (DEPTH),
        .DW    (DW_ADD),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .we      (we),
        .waddr   (beat_cnt_q[AW-1:0]),
        .wdata   (out_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == TC_ST_COLLECT);
    assign done     = (state_q == TC_ST_DONE);
    assign err      = (state_q == TC_ST_ERR);
    assign err_code = err_code_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_tc_result_collector.sv
// Directed-plus-random bench for tc_result_collector (M=N=16, TIMEOUT=8) against a
// frame-level reference model of the expected buffer contents and status.
module tb_tc_result_collector;
    import tc_pkg::*;

    localparam int DEPTH = 256;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               arm = 1'b0;
    logic signed [31:0] out_i = '0;
    logic [1:0]         out_state = TC_OS_IDLE;
    logic               rd_en = 1'b0;
    logic [7:0]         rd_addr = '0;
    logic signed [31:0] rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    logic [8:0]         beat_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [DEPTH];
    logic [31:0] sent_q [$];
    bit          last_q [$];
    bit          armed = 1'b0;
    bit          e_busy, e_done, e_err;
    logic [1:0]  e_code;
    int          e_cnt;

    tc_result_collector #(
        .M       (16),
        .N       (16),
        .DW_ADD  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .out_i     (out_i),
        .out_state (out_state),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: the frame ends at the first last-flagged beat or at beat DEPTH-1,
    // whichever comes first; anything beyond that end decides the error outcome.
    task automatic model_eval();
        int n, first_last, end_idx;
        n = sent_q.size();
        first_last = DEPTH;
        for (int i = n - 1; i >= 0; i--) if (last_q[i]) first_last = i;
        end_idx = (first_last < DEPTH - 1) ? first_last : DEPTH - 1;
        {e_busy, e_done, e_err} = 3'b000;
        e_code = TC_ERR_NONE;
        e_cnt = 0;
        if (armed) begin
            if (n <= end_idx) begin
                e_busy = 1'b1;
                e_cnt = n;
            end else begin
                e_cnt = end_idx + 1;
                if (end_idx < DEPTH - 1) begin
                    e_err = 1'b1;
                    e_code = TC_ERR_SHORT;
                end else if (n > DEPTH) begin
                    e_err = 1'b1;
                    e_code = TC_ERR_OVF;
                end else begin
                    e_done = 1'b1;
                end
            end
        end
        for (int i = 0; i < e_cnt; i++) exp_mem[i] = sent_q[i];
    endtask

    task automatic chk_status(input string tag);
        model_eval();
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".err_code"}, 32'(err_code), 32'(e_code));
        chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(e_cnt));
    endtask

    task automatic do_arm(input bit with_beat);
        arm = 1'b1;
        out_state = with_beat ? TC_OS_BEAT : TC_OS_IDLE;
        out_i = $urandom;
        tick();
        arm = 1'b0;
        out_state = TC_OS_IDLE;
        sent_q.delete();
        last_q.delete();
        armed = 1'b1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last);
        out_state = last ? TC_OS_LAST : TC_OS_BEAT;
        out_i = d;
        tick();
        out_state = TC_OS_IDLE;
        sent_q.push_back(d);
        last_q.push_back(last);
    endtask

    // Idle cycles, randomly using the reserved encoding which must also count as idle.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            out_state = ($urandom_range(1) == 1) ? 2'b10 : TC_OS_IDLE;
            out_i = $urandom;
            tick();
        end
        out_state = TC_OS_IDLE;
    endtask

    task automatic read_chk(input string tag, input int addr);
        rd_en = 1'b1;
        rd_addr = 8'(addr);
        tick();
        rd_en = 1'b0;
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
        chk($sformatf("%s.rd_data[%0d]", tag, addr), rd_data, exp_mem[addr]);
    endtask

    initial begin
        logic [31:0] old5, held;

        // Reset state
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.err_code", 32'(err_code), 32'd0);
        chk("rst.beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("rst.rd_data", rd_data, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Stray beats before arm are ignored
        for (int i = 0; i < 3; i++) send_beat($urandom, i == 2);
        sent_q.delete();
        last_q.delete();
        chk_status("stray");

        // Full frame, sequential data -100..155
        do_arm(1'b0);
        chk_status("arm1");
        for (int i = 0; i < 100; i++) send_beat(32'(i - 100), 1'b0);
        chk_status("full.mid");
        for (int i = 100; i < DEPTH; i++) send_beat(32'(i - 100), i == DEPTH - 1);
        chk_status("full.end");
        for (int a = 0; a < DEPTH; a++) read_chk("full", a);
        held = rd_data;
        tick();
        chk("hold.rd_valid", 32'(rd_valid), 32'd0);
        chk("hold.rd_data", rd_data, held);

        // Overflow: one extra beat after DONE
        send_beat(32'd7, 1'b0);
        chk_status("ovf");
        read_chk("ovf", 0);

        // Short frame with random data and random idle gaps below the timeout
        do_arm(1'b0);
        for (int i = 0; i < 200; i++) begin
            send_beat($urandom, i == 199);
            if (i != 199) gap($urandom_range(3));
        end
        chk_status("short");
        read_chk("short", 199);
        for (int k = 0; k < 6; k++) read_chk("short", $urandom_range(DEPTH - 1));

        // Random full frame; last flag on the final beat is optional
        do_arm(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send_beat($urandom, (i == DEPTH - 1) && ($urandom_range(1) == 1));
            if (i != DEPTH - 1) gap($urandom_range(2));
        end
        chk_status("rand");
        for (int k = 0; k < 8; k++) read_chk("rand", $urandom_range(DEPTH - 1));

        // Timeout boundary: 7 idle cycles survive, the 8th trips
        do_arm(1'b0);
        for (int i = 0; i < 10; i++) send_beat($urandom, 1'b0);
        gap(7);
        chk("tmo7.busy", 32'(busy), 32'd1);
        chk("tmo7.err", 32'(err), 32'd0);
        gap(1);
        chk("tmo8.err", 32'(err), 32'd1);
        chk("tmo8.err_code", 32'(err_code), 32'(TC_ERR_TIMEOUT));
        chk("tmo8.beat_cnt", 32'(beat_cnt), 32'd10);
        chk("tmo8.busy", 32'(busy), 32'd0);
        model_eval();

        // Read/write collision on address 5
        do_arm(1'b0);
        for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0);
        old5 = exp_mem[5];
        rd_en = 1'b1;
        rd_addr = 8'd5;
        send_beat(32'h55, 1'b0);
        rd_en = 1'b0;
        chk("coll.old", rd_data, old5);
        chk_status("coll");
        read_chk("coll.new", 5);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 20; i++) send_beat($urandom, 1'b0);
        reset = 1'b0;
        #2;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.err", 32'(err), 32'd0);
        chk("arst.beat_cnt", 32'(beat_cnt), 32'd0);
        chk("arst.rd_data", rd_data, 32'd0);
        tick();
        reset = 1'b1;
        armed = 1'b0;
        sent_q.delete();
        last_q.delete();
        for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0);
        sent_q.delete();
        last_q.delete();
        chk_status("postrst");

        // Re-arm mid-frame; the beat coinciding with arm is dropped
        do_arm(1'b0);
        for (int i = 0; i < 50; i++) send_beat($urandom, 1'b0);
        chk_status("rearm.mid");
        do_arm(1'b1);
        chk_status("rearm.arm");
        for (int i = 0; i < DEPTH; i++) send_beat($urandom, i == DEPTH - 1);
        chk_status("rearm.end");
        read_chk("rearm", 0);
        read_chk("rearm", 49);
        read_chk("rearm", 50);
        read_chk("rearm", 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
